// File: rtl/mem_lsu_if.sv
// Request/response and data-RAM port bundle for the load/store unit.
// slave = the LSU's own view, master = the execute stage / RAM environment.
interface mem_lsu_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  req_valid_i;
    logic                  req_ready_o;
    logic                  req_store_i;
    logic [1:0]            req_size_i;
    logic                  req_unsigned_i;
    logic [ADDR_WIDTH-1:0] req_addr_i;
    logic [DATA_WIDTH-1:0] req_wdata_i;
    logic                  resp_valid_o;
    logic [DATA_WIDTH-1:0] resp_rdata_o;
    logic                  resp_err_o;
    logic                  mem_en_o;
    logic [ADDR_WIDTH-1:0] mem_addr_o;
    logic [DATA_WIDTH-1:0] mem_wdata_o;
    logic [3:0]            mem_wr_mask_o;
    logic [DATA_WIDTH-1:0] mem_rdata_i;

    modport slave (
        input  req_valid_i, req_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, mem_rdata_i,
        output req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               mem_en_o, mem_addr_o, mem_wdata_o, mem_wr_mask_o
    );

    modport master (
        output req_valid_i, req_store_i, req_size_i, req_unsigned_i,
               req_addr_i, req_wdata_i, mem_rdata_i,
        input  req_ready_o, resp_valid_o, resp_rdata_o, resp_err_o,
               mem_en_o, mem_addr_o, mem_wdata_o, mem_wr_mask_o
    );
endinterface

// File: rtl/mem_lsu.sv
// Single-transaction load/store initiator for the synchronous data RAM.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input logic       clk,
    input logic       reset,
    mem_lsu_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                state, next_state;
    logic                  store_q, unsigned_q, err_q;
    logic [1:0]            size_q, off_q;
    logic [DATA_WIDTH-1:0] rdata_q;
    logic                  accept, illegal;
    logic [1:0]            off_in;
    logic [3:0]            mask_in;
    logic [DATA_WIDTH-1:0] wdata_in, load_ext;
    logic [7:0]            byte_lane;
    logic [15:0]           half_lane;

    assign accept = (state == IDLE) && bus.req_valid_i;
    assign off_in = bus.req_addr_i[1:0];

    always_comb begin
        illegal = (bus.req_size_i == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if (bus.req_size_i == 2'b01 && off_in[0])
            illegal = 1'b1;
        if (bus.req_size_i == 2'b10 && off_in != 2'b00)
            illegal = 1'b1;
`endif
    end

    // Store lanes are replicated so the RAM only needs the byte mask to pick the target bytes.
    always_comb begin
        mask_in  = 4'b0000;
        wdata_in = '0;
        if (bus.req_store_i) begin
            case (bus.req_size_i)
                2'b00: begin
                    mask_in  = 4'b0001 << off_in;
                    wdata_in = {4{bus.req_wdata_i[7:0]}};
                end
                2'b01: begin
                    mask_in  = 4'b0011 << {off_in[1], 1'b0};
                    wdata_in = {2{bus.req_wdata_i[15:0]}};
                end
                2'b10: begin
                    mask_in  = 4'b1111;
                    wdata_in = bus.req_wdata_i;
                end
                default: begin
                    mask_in  = 4'b0000;
                    wdata_in = '0;
                end
            endcase
        end
    end

    always_comb begin
        byte_lane = bus.mem_rdata_i[8*off_q +: 8];
        half_lane = bus.mem_rdata_i[16*off_q[1] +: 16];
        case (size_q)
            2'b00:   load_ext = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            2'b01:   load_ext = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            2'b10:   load_ext = bus.mem_rdata_i;
            default: load_ext = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = illegal ? DONE : ISSUE;
            ISSUE:   next_state = store_q ? DONE : WAIT;
            WAIT:    next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready_o  = (state == IDLE);
        bus.resp_valid_o = (state == DONE);
        bus.resp_err_o   = (state == DONE) && err_q;
        bus.resp_rdata_o = (state == DONE) ? rdata_q : '0;
    end

    // RAM port is loaded on the accept edge so the enable is seen for exactly the ISSUE cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            store_q           <= 1'b0;
            unsigned_q        <= 1'b0;
            size_q            <= 2'b00;
            off_q             <= 2'b00;
            err_q             <= 1'b0;
            rdata_q           <= '0;
            bus.mem_en_o      <= 1'b0;
            bus.mem_addr_o    <= '0;
            bus.mem_wdata_o   <= '0;
            bus.mem_wr_mask_o <= 4'b0000;
        end else begin
            bus.mem_en_o      <= 1'b0;
            bus.mem_addr_o    <= '0;
            bus.mem_wdata_o   <= '0;
            bus.mem_wr_mask_o <= 4'b0000;
            if (accept) begin
                store_q    <= bus.req_store_i;
                unsigned_q <= bus.req_unsigned_i;
                size_q     <= bus.req_size_i;
                off_q      <= off_in;
                err_q      <= illegal;
                rdata_q    <= '0;
                if (!illegal) begin
                    bus.mem_en_o      <= 1'b1;
                    bus.mem_addr_o    <= bus.req_addr_i;
                    bus.mem_wdata_o   <= wdata_in;
                    bus.mem_wr_mask_o <= mask_in;
                end
            end
            if (state == WAIT)
                rdata_q <= load_ext;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// Scoreboard bench for mem_lsu: an arithmetic reference model predicts RAM traffic and responses.
// Honours LSU_MISALIGN_TRAP_EN the same way the design does.
module tb_mem_lsu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    mem_lsu_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus();
    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int cyc; logic [31:0] rdata; logic err;} resp_t;
    typedef struct {int cyc; logic [31:0] addr; logic [3:0] mask; logic [31:0] wdata;} memop_t;

    resp_t       resp_q[$];
    memop_t      mem_q[$];
    logic [31:0] ref_mem[64];
    logic [31:0] ram[64];
    logic [31:0] ram_rdata;
    bit          ram_ready = 1'b0;

    assign bus.mem_rdata_i = ram_rdata;

    function automatic logic [31:0] seed_word(int i);
        return (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
    endfunction

    function automatic void checkOutput(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Environment RAM: read data is valid only the cycle after an enabled read, garbage otherwise.
    always @(posedge clk) begin
        if (!ram_ready) begin
            for (int i = 0; i < 64; i++) ram[i] <= seed_word(i);
            ram_ready <= 1'b1;
        end else if (bus.mem_en_o && bus.mem_wr_mask_o != 4'b0000) begin
            for (int b = 0; b < 4; b++)
                if (bus.mem_wr_mask_o[b])
                    ram[bus.mem_addr_o[7:2]][8*b +: 8] <= bus.mem_wdata_o[8*b +: 8];
        end
        if (bus.mem_en_o && bus.mem_wr_mask_o == 4'b0000)
            ram_rdata <= ram[bus.mem_addr_o[7:2]];
        else
            ram_rdata <= $urandom;
    end

    // Monitor: pops expectations whenever the DUT shows a RAM enable or a response.
    always @(negedge clk) begin
        memop_t m;
        resp_t  r;
        if (!reset && ram_ready) begin
            if (bus.mem_en_o) begin
                if (mem_q.size() == 0) begin
                    checkOutput("unexpected_mem_en", 32'(bus.mem_en_o), 32'd0);
                end else begin
                    m = mem_q.pop_front();
                    checkOutput("mem_en_cycle", cyc, m.cyc);
                    checkOutput("mem_word_addr", bus.mem_addr_o >> 2, m.addr >> 2);
                    checkOutput("mem_wr_mask", 32'(bus.mem_wr_mask_o), 32'(m.mask));
                    if (m.mask != 4'b0000)
                        checkOutput("mem_wdata", bus.mem_wdata_o, m.wdata);
                end
            end else begin
                checkOutput("idle_mem_mask", 32'(bus.mem_wr_mask_o), 32'd0);
                checkOutput("idle_mem_addr", bus.mem_addr_o, 32'd0);
                checkOutput("idle_mem_wdata", bus.mem_wdata_o, 32'd0);
            end
            if (bus.resp_valid_o) begin
                checkOutput("ready_during_resp", 32'(bus.req_ready_o), 32'd0);
                if (resp_q.size() == 0) begin
                    checkOutput("unexpected_resp", 32'(bus.resp_valid_o), 32'd0);
                end else begin
                    r = resp_q.pop_front();
                    checkOutput("resp_cycle", cyc, r.cyc);
                    checkOutput("resp_rdata", bus.resp_rdata_o, r.rdata);
                    checkOutput("resp_err", 32'(bus.resp_err_o), 32'(r.err));
                end
            end
        end
    end

    task automatic checkResetState();
        checkOutput("rst_req_ready", 32'(bus.req_ready_o), 32'd1);
        checkOutput("rst_resp_valid", 32'(bus.resp_valid_o), 32'd0);
        checkOutput("rst_resp_rdata", bus.resp_rdata_o, 32'd0);
        checkOutput("rst_resp_err", 32'(bus.resp_err_o), 32'd0);
        checkOutput("rst_mem_en", 32'(bus.mem_en_o), 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr_o, 32'd0);
        checkOutput("rst_mem_wdata", bus.mem_wdata_o, 32'd0);
        checkOutput("rst_mem_mask", 32'(bus.mem_wr_mask_o), 32'd0);
    endtask

    // Drives one request and records what the RAM port and the response must look like.
    task automatic applyStimulus(input bit st, input logic [1:0] sz, input bit uns,
                                 input logic [31:0] a, input logic [31:0] w);
        int          guard = 0;
        int          n, idx, sh;
        logic [31:0] word, v, wd, mask;
        bit          err;
        memop_t      m;
        resp_t       r;
        @(negedge clk);
        while (!bus.req_ready_o && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!bus.req_ready_o) begin
            checkOutput("ready_timeout", 32'(bus.req_ready_o), 32'd1);
            return;
        end
        n = cyc;
        bus.req_valid_i    = 1'b1;
        bus.req_store_i    = st;
        bus.req_size_i     = sz;
        bus.req_unsigned_i = uns;
        bus.req_addr_i     = a;
        bus.req_wdata_i    = w;

        idx = int'(a[7:2]);
        err = (sz == 2'b11);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00))
            err = 1'b1;
`endif
        r.rdata = 32'd0;
        r.err   = err;
        if (err) begin
            r.cyc = n + 1;
        end else begin
            if (sz == 2'b00) sh = 8 * int'(a[1:0]);
            else if (sz == 2'b01) sh = 16 * int'(a[1]);
            else sh = 0;
            if (st) begin
                if (sz == 2'b00) begin
                    mask = 32'd1 << (sh / 8);
                    wd   = (w & 32'hFF) * 32'h01010101;
                    ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((w & 32'hFF) << sh);
                end else if (sz == 2'b01) begin
                    mask = 32'd3 << (sh / 8);
                    wd   = (w & 32'hFFFF) * 32'h00010001;
                    ref_mem[idx] = (ref_mem[idx] & ~(32'hFFFF << sh)) | ((w & 32'hFFFF) << sh);
                end else begin
                    mask = 32'd15;
                    wd   = w;
                    ref_mem[idx] = w;
                end
                r.cyc = n + 2;
            end else begin
                mask = 32'd0;
                wd   = 32'd0;
                word = ref_mem[idx];
                if (sz == 2'b00) begin
                    v = (word >> sh) & 32'hFF;
                    if (!uns && v >= 32'd128) v = v - 32'd256;
                end else if (sz == 2'b01) begin
                    v = (word >> sh) & 32'hFFFF;
                    if (!uns && v >= 32'd32768) v = v - 32'd65536;
                end else begin
                    v = word;
                end
                r.rdata = v;
                r.cyc   = n + 3;
            end
            m.cyc   = n + 1;
            m.addr  = a;
            m.mask  = mask[3:0];
            m.wdata = wd;
            mem_q.push_back(m);
        end
        resp_q.push_back(r);

        @(posedge clk);
        #1;
        bus.req_valid_i    = 1'b0;
        bus.req_store_i    = 1'($urandom);
        bus.req_size_i     = 2'($urandom);
        bus.req_unsigned_i = 1'($urandom);
        bus.req_addr_i     = $urandom;
        bus.req_wdata_i    = $urandom;
    endtask

    // A load is cut off by reset while waiting for RAM data; it must vanish without a response.
    task automatic resetInWait();
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0104, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        resp_q.delete();
        mem_q.delete();
        @(negedge clk);
        checkResetState();
        #1 reset = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [1:0] sz;
        bus.req_valid_i    = 1'b0;
        bus.req_store_i    = 1'b0;
        bus.req_size_i     = 2'b00;
        bus.req_unsigned_i = 1'b0;
        bus.req_addr_i     = '0;
        bus.req_wdata_i    = '0;
        for (int i = 0; i < 64; i++) ref_mem[i] = seed_word(i);

        repeat (3) @(negedge clk);
        checkResetState();
        #1 reset = 1'b0;

        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'hDEADBEEF);
        applyStimulus(1'b1, 2'b00, 1'b0, 32'h0000_0103, 32'h000000A5);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0100, 32'd0);
        applyStimulus(1'b1, 2'b10, 1'b0, 32'h0000_0100, 32'h80FF7F01);
        applyStimulus(1'b0, 2'b00, 1'b0, 32'h0000_0103, 32'd0);
        applyStimulus(1'b0, 2'b00, 1'b1, 32'h0000_0103, 32'd0);
        applyStimulus(1'b0, 2'b01, 1'b0, 32'h0000_0102, 32'd0);
        applyStimulus(1'b0, 2'b11, 1'b0, 32'h0000_0100, 32'd0);
        applyStimulus(1'b0, 2'b10, 1'b0, 32'h0000_0102, 32'd0);
        applyStimulus(1'b1, 2'b01, 1'b0, 32'h0000_0081, 32'h1234CAFE);
        applyStimulus(1'b0, 2'b01, 1'b1, 32'h0000_0082, 32'd0);

        resetInWait();

        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            applyStimulus(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                          $urandom, $urandom);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        for (int i = 0; i < 20 && (resp_q.size() != 0 || mem_q.size() != 0); i++)
            @(negedge clk);
        checkOutput("pending_expectations", 32'(resp_q.size() + mem_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/mem_lsu.md
# mem_lsu

Load/store initiator that drives the core's synchronous word-addressed data RAM port on behalf of the execute stage. It accepts one byte, halfword or word load or store request per transaction and generates the chip enable, byte write mask and lane-replicated write data. For loads, it captures the RAM read word, then extracts and sign- or zero-extends the addressed bytes. It sits between the execute stage and the data RAM, one transaction in flight at a time.

## Interface
- ADDR_WIDTH, 32, byte address width.
- DATA_WIDTH, 32, data width; only 32 is supported.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when high together with req_valid_i.
- req_store_i  in  1  1 = store, 0 = load.
- req_size_i  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned_i  in  1  load zero-extend when 1, sign-extend when 0.
- req_addr_i  in  ADDR_WIDTH  byte address.
- req_wdata_i  in  DATA_WIDTH  store data, right-justified.
- resp_valid_o  out  1  one-cycle pulse; transaction complete.
- resp_rdata_o  out  DATA_WIDTH  extended load result; 0 for stores and errors.
- resp_err_o  out  1  transaction rejected; qualified by resp_valid_o.
- mem_en_o  out  1  RAM chip enable, active high.
- mem_addr_o  out  ADDR_WIDTH  RAM byte address; RAM ignores bits [1:0].
- mem_wdata_o  out  DATA_WIDTH  lane-replicated write data.
- mem_wr_mask_o  out  4  byte write enables; 0000 = read.
- mem_rdata_i  in  DATA_WIDTH  RAM read word, valid the cycle after the enabled edge.

## Operation
- FSM states:
  - IDLE: req_ready_o=1. A handshake registers the request. Next state is ISSUE, or DONE if the request is illegal.
  - ISSUE: mem_en_o=1 for exactly one cycle. Next state is WAIT for a load, DONE for a store.
  - WAIT: mem_rdata_i is captured and extracted at the end of this cycle. Next state is DONE.
  - DONE: resp_valid_o=1 for one cycle. Next state is IDLE.
- req_ready_o is high only in IDLE.
- No new request is accepted in the cycle of a response pulse.
- Lane offset o = addr[1:0].
- Write mask:
  - byte: 0001<<o
  - half: 0011<<{o[1],0}
  - word: 1111
  - mask is 0000 for loads.
- Write data replication:
  - byte: {4{wdata[7:0]}}
  - half: {2{wdata[15:0]}}
  - word: wdata
- Load extract:
  - byte = rdata[8*o+7:8*o]
  - half = rdata[16*o[1]+15:16*o[1]]
  - word = rdata
  - bit 7 or bit 15 of the extracted value is replicated upward unless req_unsigned_i=1, in which case the upper bits are zero.
- req_size_i=11 is illegal:
  - no RAM access is made.
  - DONE is entered directly from the accept edge with resp_err_o=1 and resp_rdata_o=0.
- All mem_* outputs are registered. Outside ISSUE they return to 0: en 0, mask 0000, addr 0, wdata 0.
- Reset, including mid-transaction:
  - state returns to IDLE at the next edge.
  - req_ready_o=1, resp_valid_o=0, resp_rdata_o=0, resp_err_o=0.
  - mem_en_o=0, mem_addr_o=0, mem_wdata_o=0, mem_wr_mask_o=0000.
  - the in-flight transaction is dropped with no response.

## Timing
- Accept edge = E0 (handshake in IDLE).
- Load:
  - ISSUE in cycle after E0 (mem_en_o=1); RAM accesses at E1.
  - WAIT samples mem_rdata_i at E2.
  - resp_valid_o high in the cycle after E2.
  - req_ready_o high again after E3.
  - Latency: 3 cycles from accept to response, 4-cycle issue interval.
- Store:
  - ISSUE after E0, DONE after E1.
  - Latency: 2 cycles, 3-cycle issue interval.
- Illegal request: DONE in the cycle after E0.
- Response timing does not depend on req_valid_i after acceptance.

## Configuration
- LSU_MISALIGN_TRAP_EN defined:
  - a half access with addr[0]=1, or a word access with addr[1:0]≠00, is misaligned.
  - a misaligned request behaves like an illegal size: no RAM access, DONE after E0, resp_err_o=1, resp_rdata_o=0.
- LSU_MISALIGN_TRAP_EN undefined:
  - misaligned requests are silently aligned: half uses o[1] only, word ignores o.
  - the access proceeds normally with resp_err_o=0.

## Test plan
- Store word 0xDEADBEEF to 0x100:
  - ISSUE shows en=1, mask=1111, wdata=0xDEADBEEF, addr=0x100.
  - resp_valid 2 cycles after accept, err=0.
- Store byte 0xA5 to 0x103:
  - mask=1000, wdata=0xA5A5A5A5.
  - a subsequent word load of 0x100 with RAM word 0xA5ADBEEF returns 0xA5ADBEEF 3 cycles after accept.
- Loads from address 0x103, RAM word 0x80FF7F01:
  - signed byte load returns 0xFFFFFF80.
  - unsigned byte load returns 0x00000080.
  - signed half load at 0x102 returns 0xFFFF80FF.
- Size 11 request: no mem_en_o pulse, resp_valid_o one cycle after accept with err=1 and rdata=0.
- Word load at 0x102, misaligned:
  - with LSU_MISALIGN_TRAP_EN: err=1, no enable pulse.
  - without: access to word 0x100, err=0.
- reset asserted in WAIT: next cycle state IDLE, req_ready=1, all mem_* and resp_* outputs 0, no resp_valid pulse.
